// File: rtl/eaf_pkg.sv
// Shared types for the EAF command sequencer: FSM state encoding and address type.
package eaf_pkg;
  localparam int EAF_ADDR_W = 32;

  typedef enum logic [1:0] {IDLE, TEST, INSERT, DONE} eaf_ctrl_state_e;

  typedef logic [EAF_ADDR_W-1:0] eaf_addr_t;
endpackage

// File: rtl/eaf_ins_fifo.sv
// Synchronous FIFO for evicted addresses; push accepted only when not full (even if popping),
// head is combinational from the read pointer, one-cycle write-to-read latency.
module eaf_ins_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [W-1:0]               push_dat,
  input  logic                       pop,
  output logic [W-1:0]               head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic          push_acc, pop_acc;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign push_acc = push && !full;
  assign pop_acc  = pop && !empty;
  assign head     = mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_acc) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop_acc) rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push_acc) - CW'(pop_acc);
    end
  end
endmodule

// File: rtl/eaf_ctrl.sv
// Arbitrates the EAF command port between miss-path tests and buffered evictions.
// Strobe one cycle after grant; test ack one cycle after EAF response; inserts stall when FIFO full.
module eaf_ctrl
  import eaf_pkg::*;
#(
  parameter int ADDR_W       = EAF_ADDR_W,
  parameter int INS_DEPTH    = 4,
  parameter int STARVE_LIMIT = 8,
  parameter int TIMEOUT      = 64
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           test_req_i,
  input  logic [ADDR_W-1:0]              test_addr_i,
  output logic                           test_ack_o,
  output logic                           test_hit_o,
  input  logic                           ins_req_i,
  input  logic [ADDR_W-1:0]              ins_addr_i,
  output logic                           ins_ready_o,
  output logic [ADDR_W-1:0]              eaf_addr_o,
  output logic                           eaf_test_o,
  output logic                           eaf_insert_o,
  input  logic                           eaf_resp_i,
  input  logic                           eaf_exists_i,
  output logic                           busy_o,
  output logic [$clog2(INS_DEPTH+1)-1:0] ins_count_o,
  output logic                           err_o
);
  localparam int SW = $clog2(STARVE_LIMIT+1);
  localparam int TW = $clog2(TIMEOUT+1);

  eaf_ctrl_state_e   state, state_nxt;
  logic [ADDR_W-1:0] addr_nxt, fifo_head;
  logic              test_nxt, insert_nxt, ack_nxt, hit_nxt, err_nxt, pop;
  logic              fifo_full, fifo_empty;
  logic [SW-1:0]     starve_cnt, starve_nxt;
  logic [TW-1:0]     wd_cnt, wd_nxt;

  eaf_ins_fifo #(.W(ADDR_W), .DEPTH(INS_DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (ins_req_i),
    .push_dat (ins_addr_i),
    .pop      (pop),
    .head     (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (ins_count_o)
  );

  assign ins_ready_o = !fifo_full;
  assign busy_o      = (state != IDLE);

  always_comb begin
    state_nxt  = state;
    addr_nxt   = eaf_addr_o;
    test_nxt   = eaf_test_o;
    insert_nxt = eaf_insert_o;
    ack_nxt    = 1'b0;
    hit_nxt    = test_hit_o;
    err_nxt    = err_o;
    starve_nxt = starve_cnt;
    wd_nxt     = '0;
    pop        = 1'b0;
    unique case (state)
      IDLE: begin
        addr_nxt = '0;
        // A full FIFO holds tests off so the evicted address is never lost.
        if (test_req_i && !fifo_full && (starve_cnt < SW'(STARVE_LIMIT))) begin
          state_nxt = TEST;
          addr_nxt  = test_addr_i;
          test_nxt  = 1'b1;
          if (fifo_empty)                             starve_nxt = '0;
          else if (starve_cnt != SW'(STARVE_LIMIT))   starve_nxt = starve_cnt + SW'(1);
        end else if (!fifo_empty) begin
          state_nxt  = INSERT;
          addr_nxt   = fifo_head;
          insert_nxt = 1'b1;
          starve_nxt = '0;
        end
      end
      TEST: begin
        if (eaf_resp_i || (wd_cnt == TW'(TIMEOUT))) begin
          // An aborted test reports a miss: low insertion priority is the safe answer.
          state_nxt = DONE;
          test_nxt  = 1'b0;
          ack_nxt   = 1'b1;
          hit_nxt   = eaf_resp_i && eaf_exists_i;
          err_nxt   = err_o || !eaf_resp_i;
        end else begin
          wd_nxt = wd_cnt + TW'(1);
        end
      end
      INSERT: begin
        if (eaf_resp_i || (wd_cnt == TW'(TIMEOUT))) begin
          state_nxt  = IDLE;
          insert_nxt = 1'b0;
          pop        = 1'b1;
          err_nxt    = err_o || !eaf_resp_i;
        end else begin
          wd_nxt = wd_cnt + TW'(1);
        end
      end
      DONE: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      eaf_addr_o   <= '0;
      eaf_test_o   <= 1'b0;
      eaf_insert_o <= 1'b0;
      test_ack_o   <= 1'b0;
      test_hit_o   <= 1'b0;
      err_o        <= 1'b0;
      starve_cnt   <= '0;
      wd_cnt       <= '0;
    end else begin
      state        <= state_nxt;
      eaf_addr_o   <= addr_nxt;
      eaf_test_o   <= test_nxt;
      eaf_insert_o <= insert_nxt;
      test_ack_o   <= ack_nxt;
      test_hit_o   <= hit_nxt;
      err_o        <= err_nxt;
      starve_cnt   <= starve_nxt;
      wd_cnt       <= wd_nxt;
    end
  end
endmodule

// File: tb/tb_eaf_ctrl.sv
// Directed plus randomized bench for eaf_ctrl against a behavioural EAF (address set) and queue model.
module tb_eaf_ctrl;
  localparam int AW = 32, DEPTH = 4, SLIM = 8, TMO = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          test_req_i, test_ack_o, test_hit_o;
  logic [AW-1:0] test_addr_i, ins_addr_i, eaf_addr_o;
  logic          ins_req_i, ins_ready_o;
  logic          eaf_test_o, eaf_insert_o, eaf_resp_i, eaf_exists_i, busy_o, err_o;
  logic [2:0]    ins_count_o;

  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  eaf_ctrl #(.ADDR_W(AW), .INS_DEPTH(DEPTH), .STARVE_LIMIT(SLIM), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .test_req_i(test_req_i), .test_addr_i(test_addr_i), .test_ack_o(test_ack_o), .test_hit_o(test_hit_o),
    .ins_req_i(ins_req_i), .ins_addr_i(ins_addr_i), .ins_ready_o(ins_ready_o),
    .eaf_addr_o(eaf_addr_o), .eaf_test_o(eaf_test_o), .eaf_insert_o(eaf_insert_o),
    .eaf_resp_i(eaf_resp_i), .eaf_exists_i(eaf_exists_i),
    .busy_o(busy_o), .ins_count_o(ins_count_o), .err_o(err_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Behavioural EAF: a set of addresses, answering after a configurable latency.
  bit            mem [logic [31:0]];
  logic [31:0]   ins_log [$];
  bit            cmd_log [$];
  bit            responsive = 1'b1, rnd_lat = 1'b0, last_exists = 1'b0;
  logic [31:0]   last_test_addr = '0;
  int            lat_cfg = 1, cur_lat = 1, cnt = 0, ins_done = 0;

  initial begin
    eaf_resp_i = 1'b0;
    eaf_exists_i = 1'b0;
    forever begin
      @(negedge clk);
      if (rst === 1'b1 || eaf_resp_i) begin
        eaf_resp_i = 1'b0; eaf_exists_i = 1'b0; cnt = 0;
      end else if ((eaf_test_o || eaf_insert_o) && responsive) begin
        if (cnt == 0) cur_lat = rnd_lat ? int'($urandom_range(1, 4)) : lat_cfg;
        cnt++;
        if (cnt >= cur_lat) begin
          eaf_resp_i = 1'b1;
          if (eaf_test_o) begin
            last_test_addr = eaf_addr_o;
            last_exists    = (mem.exists(eaf_addr_o) != 0);
            eaf_exists_i   = last_exists;
            cmd_log.push_back(1'b1);
          end else begin
            mem[eaf_addr_o] = 1'b1;
            ins_log.push_back(eaf_addr_o);
            cmd_log.push_back(1'b0);
          end
        end
      end else begin
        cnt = 0;
      end
    end
  end

  always @(posedge clk) if (rst === 1'b0 && eaf_resp_i && eaf_insert_o) ins_done++;

  always @(negedge clk) if (rst === 1'b0) chk("strobe_exclusive", eaf_test_o & eaf_insert_o, 0);

  task automatic step(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input logic [31:0] a);
    ins_req_i = 1'b1; ins_addr_i = a;
    step();
    ins_req_i = 1'b0;
  endtask

  task automatic wait_ack(input string tag, output int n);
    n = 0;
    do begin step(); n++; end while (test_ack_o !== 1'b1 && n < 300);
    chk({tag, "_ack"}, test_ack_o, 1);
  endtask

  task automatic wait_count(input string tag, input int val, input int budget);
    int n = 0;
    while (ins_count_o !== 3'(val) && n < budget) begin step(); n++; end
    chk(tag, ins_count_o, val);
  endtask

  task automatic do_test(input string tag, input logic [31:0] a);
    int n;
    test_req_i = 1'b1; test_addr_i = a;
    wait_ack(tag, n);
    chk({tag, "_hit"}, test_hit_o, last_exists);
    chk({tag, "_addr"}, last_test_addr, a);
    test_req_i = 1'b0;
  endtask

  initial begin
    int n, pushed, base;
    logic [31:0] a, exp_q [$], snap;
    rst = 1'b1; test_req_i = 1'b0; test_addr_i = '0; ins_req_i = 1'b0; ins_addr_i = '0;
    step(3);
    rst = 1'b0;
    step();
    // Reset state
    chk("rst_test", eaf_test_o, 0);   chk("rst_insert", eaf_insert_o, 0);
    chk("rst_addr", eaf_addr_o, 0);   chk("rst_ack", test_ack_o, 0);
    chk("rst_hit", test_hit_o, 0);    chk("rst_busy", busy_o, 0);
    chk("rst_err", err_o, 0);         chk("rst_count", ins_count_o, 0);
    chk("rst_ready", ins_ready_o, 1);

    // Basic test: EAF answers one cycle after the strobe, ack at cycle 3
    lat_cfg = 2; mem[32'h1000] = 1'b1;
    test_req_i = 1'b1; test_addr_i = 32'h1000;
    step(); chk("basic_c1_test", eaf_test_o, 1); chk("basic_c1_addr", eaf_addr_o, 32'h1000); chk("basic_c1_busy", busy_o, 1);
    step(); chk("basic_c2_test", eaf_test_o, 1); chk("basic_c2_ack", test_ack_o, 0);
    step(); chk("basic_c3_ack", test_ack_o, 1);  chk("basic_c3_hit", test_hit_o, 1); chk("basic_c3_test", eaf_test_o, 0);
    test_req_i = 1'b0;
    step(); chk("basic_c4_ack", test_ack_o, 0);  chk("basic_c4_busy", busy_o, 0);

    // Insert drain in FIFO order
    lat_cfg = 3; ins_log.delete();
    push(32'hA0); chk("drain_cnt1", ins_count_o, 1);
    push(32'hA4); chk("drain_cnt2", ins_count_o, 2);
    push(32'hA8); chk("drain_cnt3", ins_count_o, 3);
    wait_count("drain_empty", 0, 100);
    chk("drain_n", ins_log.size(), 3);
    exp_q = '{32'hA0, 32'hA4, 32'hA8};
    foreach (exp_q[i]) if (i < ins_log.size()) chk("drain_order", ins_log[i], exp_q[i]);
    step(2);

    // FIFO full with a test pending: one insert goes first, 5th push is rejected
    lat_cfg = 6; ins_log.delete(); cmd_log.delete();
    for (int i = 0; i < DEPTH; i++) push(32'hB0 + 32'(i * 4));
    chk("full_cnt", ins_count_o, 4); chk("full_ready", ins_ready_o, 0);
    ins_req_i = 1'b1; ins_addr_i = 32'hBF0; test_req_i = 1'b1; test_addr_i = 32'hC0;
    n = 0;
    while (ins_count_o === 3'd4 && n < 40) begin step(); n++; end
    chk("full_after_pop_cnt", ins_count_o, 3); chk("full_after_pop_ready", ins_ready_o, 1);
    ins_req_i = 1'b0;
    wait_ack("full_test", n);
    test_req_i = 1'b0;
    wait_count("full_drain", 0, 200);
    chk("full_first_cmd", cmd_log[0], 0); chk("full_second_cmd", cmd_log[1], 1);
    chk("full_ins_n", ins_log.size(), 4);
    for (int i = 0; i < 4; i++) if (i < ins_log.size()) chk("full_ins_order", ins_log[i], 32'hB0 + 32'(i * 4));
    step(2);

    // Starvation: one queued entry, back-to-back tests
    lat_cfg = 1; cmd_log.delete();
    test_req_i = 1'b1; test_addr_i = 32'hD00;
    step(); ins_req_i = 1'b1; ins_addr_i = 32'hE00;
    step(); ins_req_i = 1'b0;
    chk("starve_ack0", test_ack_o, 1);
    for (int i = 1; i <= 9; i++) begin
      test_addr_i = 32'hD00 + 32'(i * 4);
      wait_ack("starve", n);
      chk("starve_hit", test_hit_o, last_exists);
      chk("starve_addr", last_test_addr, 32'hD00 + 32'(i * 4));
    end
    test_req_i = 1'b0;
    step(2);
    // Grant 0 sees an empty FIFO; eight more saturate the count, so grant 9 is the insert.
    chk("starve_ncmd", cmd_log.size(), 11);
    for (int i = 0; i < 11; i++) if (i < cmd_log.size()) chk("starve_seq", cmd_log[i], (i == 9) ? 0 : 1);
    chk("starve_cnt", ins_count_o, 0);

    // Randomized traffic against the queue/set model
    rnd_lat = 1'b1; ins_log.delete(); exp_q.delete(); pushed = 0; base = ins_done;
    for (int it = 0; it < 300; it++) begin
      int r = int'($urandom_range(0, 9));
      if (r < 4 && (pushed - (ins_done - base)) < DEPTH) begin
        chk("rnd_ready", ins_ready_o, 1);
        chk("rnd_count", ins_count_o, pushed - (ins_done - base));
        a = $urandom & 32'hFFFF_FFFC;
        push(a); exp_q.push_back(a); pushed++;
      end else if (r < 7) begin
        if (exp_q.size() > 0 && $urandom_range(0, 1) == 1) a = exp_q[$urandom_range(0, exp_q.size() - 1)];
        else a = $urandom & 32'hFFFF_FFFC;
        do_test("rnd_test", a);
      end else begin
        step();
      end
    end
    wait_count("rnd_drain", 0, 200);
    chk("rnd_ins_n", ins_log.size(), exp_q.size());
    foreach (exp_q[i]) if (i < ins_log.size()) chk("rnd_ins_order", ins_log[i], exp_q[i]);
    rnd_lat = 1'b0;
    step(3);

    // Watchdog: EAF never answers
    chk("tmo_err_before", err_o, 0);
    responsive = 1'b0; snap = 32'(ins_log.size());
    test_req_i = 1'b1; test_addr_i = 32'h1000;
    wait_ack("tmo_test", n);
    chk("tmo_latency", n, TMO + 2); chk("tmo_hit", test_hit_o, 0); chk("tmo_err", err_o, 1);
    test_req_i = 1'b0;
    push(32'hF00);
    wait_count("tmo_ins_drop", 0, TMO + 20);
    chk("tmo_err_sticky", err_o, 1);
    chk("tmo_ins_not_done", ins_log.size(), snap);
    responsive = 1'b1;
    step(3);

    // Reset during an insert with entries queued
    lat_cfg = 10;
    push(32'h100); push(32'h104); push(32'h108);
    step(2);
    chk("mid_busy", busy_o, 1); chk("mid_insert", eaf_insert_o, 1);
    rst = 1'b1; ins_req_i = 1'b1; ins_addr_i = 32'h200;
    step();
    rst = 1'b0; ins_req_i = 1'b0;
    chk("mid_rst_test", eaf_test_o, 0); chk("mid_rst_insert", eaf_insert_o, 0);
    chk("mid_rst_addr", eaf_addr_o, 0); chk("mid_rst_ack", test_ack_o, 0);
    chk("mid_rst_busy", busy_o, 0);     chk("mid_rst_err", err_o, 0);
    chk("mid_rst_count", ins_count_o, 0); chk("mid_rst_ready", ins_ready_o, 1);
    step(5);
    chk("mid_quiet_insert", eaf_insert_o, 0); chk("mid_quiet_test", eaf_test_o, 0);
    chk("mid_quiet_count", ins_count_o, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/eaf_ctrl.md
Name: eaf_ctrl

Overview:
Sequencer and arbiter in front of the Evicted Address Filter (EAF). It shares the EAF's single-command port between two requesters:
- the L1 miss path, which asks "was this address recently evicted?" (test) to pick insertion priority;
- the L1 eviction path, which records evicted addresses (insert).
Inserts are buffered in a small FIFO. Tests normally win arbitration, with a starvation bound and a response watchdog.

Parameters:
ADDR_W, 32, address width (matches EAF mem_addr)
INS_DEPTH, 4, insert FIFO depth (power of 2, >=2)
STARVE_LIMIT, 8, consecutive test grants allowed while the insert FIFO is non-empty
TIMEOUT, 64, cycles to wait for eaf_resp_i before aborting a command

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
test_req_i  in  1  miss path test request; held high until test_ack_o
test_addr_i  in  ADDR_W  address to test; stable while test_req_i high
test_ack_o  out  1  one-cycle pulse: test result valid
test_hit_o  out  1  valid with test_ack_o; 1 = address in EAF (high-priority insert)
ins_req_i  in  1  evicted address push strobe
ins_addr_i  in  ADDR_W  evicted address
ins_ready_o  out  1  FIFO not full; push accepted when ins_req_i & ins_ready_o
eaf_addr_o  out  ADDR_W  to EAF mem_addr
eaf_test_o  out  1  to EAF test_resp_i
eaf_insert_o  out  1  to EAF insert_resp_i
eaf_resp_i  in  1  from EAF resp_o: command complete
eaf_exists_i  in  1  from EAF addr_exists; sampled when eaf_resp_i=1 during a test
busy_o  out  1  state != IDLE
ins_count_o  out  $clog2(INS_DEPTH+1)  FIFO occupancy
err_o  out  1  sticky: a watchdog timeout occurred

Behaviour:
- Reset values (cycle after rst sampled high):
  - state IDLE;
  - all eaf_* outputs 0;
  - test_ack_o, test_hit_o, busy_o, err_o 0;
  - FIFO empty, ins_count_o 0, ins_ready_o 1;
  - starve and timeout counters 0.
- Reset mid-command abandons the command and drops FIFO contents.
- Pushes while rst is high are ignored.
- Outputs eaf_*, test_ack_o and test_hit_o are registered.
- FSM states: IDLE, TEST, INSERT, DONE.
- IDLE arbitration, evaluated each cycle:
  - if test_req_i and FIFO not full and starve_cnt < STARVE_LIMIT: go to TEST; latch test_addr_i into eaf_addr_o; eaf_test_o=1;
  - else if FIFO non-empty: go to INSERT; eaf_addr_o = FIFO head; eaf_insert_o=1;
  - else stay in IDLE with eaf_addr_o=0.
- FIFO full with a test pending: the insert goes first, then the test.
- Starvation counter:
  - starve_cnt increments on each TEST grant while the FIFO is non-empty;
  - it clears on each INSERT grant, and on a TEST grant when the FIFO is empty;
  - saturates at STARVE_LIMIT.
- Command hold: the address and strobe stay constant through TEST/INSERT until eaf_resp_i=1. The strobe deasserts the following cycle.
- TEST, on eaf_resp_i=1: go to DONE and capture test_hit_o = eaf_exists_i. In DONE, test_ack_o=1 for exactly one cycle, then go to IDLE. No new test is granted in DONE, so the requester has one cycle to drop test_req_i.
- INSERT, on eaf_resp_i=1: pop the FIFO head and go directly to IDLE. Back-to-back inserts therefore have one idle cycle between commands.
- Latency:
  - request seen in IDLE at cycle 0; strobe high at cycle 1;
  - EAF responding at cycle k gives test_ack_o at cycle k+1;
  - with a one-cycle EAF, test_ack_o arrives at cycle 2.
- Watchdog:
  - the counter runs in TEST/INSERT and clears on state entry;
  - when it reaches TIMEOUT without eaf_resp_i, err_o is set (sticky until rst);
  - a TEST abort goes to DONE with test_hit_o=0 (low priority, safe default);
  - an INSERT abort pops and drops the entry.
- FIFO behaviour:
  - ins_ready_o = (count != INS_DEPTH), combinational from registered count;
  - push and pop in the same cycle: accepted when not full; count unchanged;
  - at full, a push is rejected even if a pop occurs that cycle;
  - pointers wrap modulo INS_DEPTH;
  - no duplicate suppression; the EAF handles that.
- eaf_resp_i outside TEST/INSERT is ignored.
- eaf_test_o and eaf_insert_o are never high together.

Decomposition:
- Package eaf_pkg:
  - ADDR_W default;
  - typedef enum logic [1:0] eaf_ctrl_state_e {IDLE, TEST, INSERT, DONE};
  - typedef logic [ADDR_W-1:0] eaf_addr_t.
- One sub-module, eaf_ins_fifo: parameterised synchronous FIFO with full, empty and count outputs.
- Arbitration, FSM, starvation counter and watchdog live in eaf_ctrl.

Test Plan:
- Basic test: after reset, test_req_i=1 with addr 0x1000; EAF model responds 1 cycle after the strobe with exists=1. Expect eaf_test_o high 1 cycle with eaf_addr_o=0x1000, then test_ack_o=1 and test_hit_o=1 at cycle 3 from the request, busy_o low after.
- Insert drain: push 0xA0, 0xA4, 0xA8 on consecutive cycles with no tests. Expect ins_count_o 1→2→3, three eaf_insert_o commands in FIFO order with addresses 0xA0, 0xA4, 0xA8, and ins_count_o back to 0.
- FIFO full: push 4 entries, then hold ins_req_i with test_req_i pending. Expect ins_ready_o=0, the 5th push rejected, one insert issued before the test, and ins_ready_o back to 1 the cycle after the pop.
- Starvation: keep 1 entry in the FIFO and present 9 back-to-back tests (requester re-raises after each ack). Expect 8 test grants, then an INSERT grant, then tests resume.
- Timeout: issue a test, EAF never responds. Expect test_ack_o at TIMEOUT+2 cycles with test_hit_o=0 and err_o=1 held until rst. A following insert timeout drops its entry (ins_count_o decrements).
- Reset mid-command: assert rst during INSERT with 2 entries queued. Expect all outputs at reset values the next cycle, ins_count_o=0, and no eaf strobes until a new request arrives.
